// File: rtl/rvx_pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rvx_pwm_pkg
// Brief   : Register map, bit positions and byte-lane helper for rvx_pwm.
// Revision: 1.0 - initial release
// ============================================================================
package rvx_pwm_pkg;

    localparam logic [4:0] c_CTRL      = 5'h00;
    localparam logic [4:0] c_PRESCALE  = 5'h04;
    localparam logic [4:0] c_PERIOD    = 5'h08;
    localparam logic [4:0] c_STATUS    = 5'h0C;
    localparam logic [4:0] c_DUTY_BASE = 5'h10;

    localparam int c_EN     = 0;
    localparam int c_IRQ_EN = 1;
    localparam int c_POL    = 2;

    localparam int c_WRAP    = 0;
    localparam int c_CNT_LSB = 16;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rvx_pwm_channel.sv
`default_nettype none
// ============================================================================
// Module  : rvx_pwm_channel
// Brief   : One PWM channel: DUTY register, its shadow and the output flop.
// Revision: 1.0 - initial release
// ============================================================================
module rvx_pwm_channel
    import rvx_pwm_pkg::*;
#(
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_duty_wr,
    input  logic [31:0]              i_wdata,
    input  logic [3:0]               i_wstrb,
    input  logic                     i_load,
    input  logic                     i_en,
    input  logic                     i_pol,
    input  logic [COUNTER_WIDTH-1:0] i_counter,
    output logic [COUNTER_WIDTH-1:0] o_duty,
    output logic                     o_pwm
);

    logic [COUNTER_WIDTH-1:0] r_duty;
    logic [COUNTER_WIDTH-1:0] r_duty_active;
    logic                     r_pwm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_duty        <= '0;
            r_duty_active <= '0;
            r_pwm         <= 1'b0;
        end else begin
            if (i_duty_wr) begin
                r_duty <= COUNTER_WIDTH'(merge_bytes(32'(r_duty), i_wdata, i_wstrb));
            end
            if (i_load) begin
                r_duty_active <= r_duty;
            end
            r_pwm <= i_en ? ((i_counter < r_duty_active) ^ i_pol) : i_pol;
        end
    end

    assign o_duty = r_duty;
    assign o_pwm  = r_pwm;

endmodule
`default_nettype wire

// File: rtl/rvx_pwm.sv
`default_nettype none
// ============================================================================
// Module  : rvx_pwm
// Brief   : Bus-mapped multi-channel PWM with shared prescaler/period counter.
// Revision: 1.0 - initial release
// ============================================================================
module rvx_pwm
    import rvx_pwm_pkg::*;
#(
    parameter int NUM_CHANNELS  = 4,
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4:0]              rw_address,
    output logic [31:0]             read_data,
    input  logic                    read_request,
    output logic                    read_response,
    input  logic [31:0]             write_data,
    input  logic [3:0]              write_strobe,
    input  logic                    write_request,
    output logic                    write_response,
    output logic [NUM_CHANNELS-1:0] pwm_out,
    output logic                    irq
);

    logic [2:0]               r_ctrl;
    logic [COUNTER_WIDTH-1:0] r_prescale;
    logic [COUNTER_WIDTH-1:0] r_period;
    logic [COUNTER_WIDTH-1:0] r_period_active;
    logic [COUNTER_WIDTH-1:0] r_presc_cnt;
    logic [COUNTER_WIDTH-1:0] r_counter;
    logic                     r_wrap;
    logic                     r_irq;
    logic [31:0]              r_read_data;
    logic                     r_read_response;
    logic                     r_write_response;

    logic [4:0]               w_addr;
    logic                     w_en;
    logic                     w_tick;
    logic                     w_wrap;
    logic                     w_load;
    logic                     w_wrap_clr;
    logic [31:0]              w_rdata;
    logic [COUNTER_WIDTH-1:0] w_duty [4];

    // Low address bits are don't-care; masking keeps every offset word aligned.
    assign w_addr     = rw_address & 5'h1C;
    assign w_en       = r_ctrl[c_EN];
    assign w_tick     = w_en && (r_presc_cnt == r_prescale);
    assign w_wrap     = w_tick && (r_counter >= r_period_active);
    assign w_load     = w_wrap || !w_en;
    assign w_wrap_clr = write_request && (w_addr == c_STATUS) &&
                        write_strobe[0] && write_data[c_WRAP];

    always_comb begin
        w_rdata = '0;
        case (w_addr)
            c_CTRL:     w_rdata = 32'(r_ctrl);
            c_PRESCALE: w_rdata = 32'(r_prescale);
            c_PERIOD:   w_rdata = 32'(r_period);
            c_STATUS: begin
                w_rdata[c_WRAP]           = r_wrap;
                w_rdata[c_CNT_LSB +: 16]  = 16'(r_counter);
            end
            default:    w_rdata = 32'(w_duty[w_addr[3:2]]);
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ctrl           <= '0;
            r_prescale       <= '0;
            r_period         <= '0;
            r_period_active  <= '0;
            r_presc_cnt      <= '0;
            r_counter        <= '0;
            r_wrap           <= 1'b0;
            r_irq            <= 1'b0;
            r_read_data      <= '0;
            r_read_response  <= 1'b0;
            r_write_response <= 1'b0;
        end else begin
            if (write_request) begin
                case (w_addr)
                    c_CTRL:     r_ctrl     <= 3'(merge_bytes(32'(r_ctrl), write_data, write_strobe));
                    c_PRESCALE: r_prescale <= COUNTER_WIDTH'(merge_bytes(32'(r_prescale), write_data, write_strobe));
                    c_PERIOD:   r_period   <= COUNTER_WIDTH'(merge_bytes(32'(r_period), write_data, write_strobe));
                    default: ;
                endcase
            end
            r_read_response  <= read_request;
            r_read_data      <= read_request ? w_rdata : 32'h0;
            r_write_response <= write_request;

            if (!w_en || w_tick) r_presc_cnt <= '0;
            else                 r_presc_cnt <= r_presc_cnt + 1'b1;

            if (!w_en)           r_counter <= '0;
            else if (w_wrap)     r_counter <= '0;
            else if (w_tick)     r_counter <= r_counter + 1'b1;

            // Shadows follow the registers while disabled so enabling starts fresh.
            if (w_load) r_period_active <= r_period;

            if (w_wrap)          r_wrap <= 1'b1;
            else if (w_wrap_clr) r_wrap <= 1'b0;

            r_irq <= r_wrap & r_ctrl[c_IRQ_EN];
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_duty
        if (i < NUM_CHANNELS) begin : g_ch
            rvx_pwm_channel #(
                .COUNTER_WIDTH(COUNTER_WIDTH)
            ) u_ch (
                .clk       (clock),
                .rst       (reset),
                .i_duty_wr (write_request && (w_addr == c_DUTY_BASE + 5'(4 * i))),
                .i_wdata   (write_data),
                .i_wstrb   (write_strobe),
                .i_load    (w_load),
                .i_en      (w_en),
                .i_pol     (r_ctrl[c_POL]),
                .i_counter (r_counter),
                .o_duty    (w_duty[i]),
                .o_pwm     (pwm_out[i])
            );
        end else begin : g_none
            assign w_duty[i] = '0;
        end
    end

    assign read_data      = r_read_data;
    assign read_response  = r_read_response;
    assign write_response = r_write_response;
    assign irq            = r_irq;

endmodule
`default_nettype wire
